// File: rtl/issue_queue_fifo.sv
// In-order first-word-fall-through issue queue with occupancy count, almost-full
// back-pressure, flush, and a sticky overflow/underflow error flag.
module issue_queue_fifo #(
    parameter int unsigned size         = 32,
    parameter int unsigned depth        = 8,
    parameter int unsigned afull_thresh = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push_front,
    input  logic [size-1:0]           din,
    input  logic                      pop_back,
    output logic [size-1:0]           dout,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(depth):0]    count,
    output logic                      err
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(afull_thresh);

    logic [size-1:0]  mem_q [depth];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic empty_s;
    logic full_s;
    logic do_push;
    logic do_pop;
    logic mem_we;

    // Status decoded from registered count only; no input-to-status path.
    always_comb begin
        empty_s = (cnt_q == '0);
        full_s  = (cnt_q == DEPTH_C);
    end

    always_comb begin
        do_pop  = pop_back & ~empty_s;
        do_push = push_front & (~full_s | do_pop);

        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        mem_we = 1'b0;

        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            mem_we = do_push;
            if (do_push) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (do_pop) begin
                rp_d = rp_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if ((push_front & full_s & ~do_pop) | (pop_back & empty_s)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage is not reset; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[wp_q] <= din;
        end
    end

    always_comb begin
        dout        = empty_s ? '0 : mem_q[rp_q];
        empty       = empty_s;
        full        = full_s;
        almost_full = (cnt_q >= AFULL_C);
        count       = cnt_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_issue_queue_fifo.sv
// Directed bench for issue_queue_fifo (depth 4, threshold 3) with a scoreboard
// queue of expected post-edge states checked by an independent monitor.
module tb_issue_queue_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       push_front;
    logic [7:0] din;
    logic       pop_back;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [2:0] count;
    logic       err;

    issue_queue_fifo #(
        .size        (8),
        .depth       (4),
        .afull_thresh(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_front (push_front),
        .din        (din),
        .pop_back   (pop_back),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .err        (err)
    );

    typedef struct packed {
        logic [2:0] cnt;
        logic       err;
        logic [7:0] dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Monitor: every edge that has an outstanding expectation is compared.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("count",       {29'b0, count},       {29'b0, mon_e.cnt});
            chk("empty",       {31'b0, empty},       {31'b0, (mon_e.cnt == 3'd0)});
            chk("full",        {31'b0, full},        {31'b0, (mon_e.cnt == 3'd4)});
            chk("almost_full", {31'b0, almost_full}, {31'b0, (mon_e.cnt >= 3'd3)});
            chk("err",         {31'b0, err},         {31'b0, mon_e.err});
            chk("dout",        {24'b0, dout},        {24'b0, mon_e.dout});
        end
    end

    task automatic step(input logic r, input logic f, input logic pu, input logic [7:0] d,
                        input logic po, input int ec, input logic ee, input logic [7:0] ed);
        exp_t e;
        rst        = r;
        flush      = f;
        push_front = pu;
        din        = d;
        pop_back   = po;
        e.cnt  = 3'(ec);
        e.err  = ee;
        e.dout = ed;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; push_front = 1'b0; din = 8'h00; pop_back = 1'b0;

        // Reset, then fill to full and overflow
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h77, 1, 0, 0, 8'h00);
        step(1, 0, 1, 8'hA1, 0, 1, 0, 8'hA1);
        step(1, 0, 1, 8'hA2, 0, 2, 0, 8'hA1);
        step(1, 0, 1, 8'hA3, 0, 3, 0, 8'hA1);
        step(1, 0, 1, 8'hA4, 0, 4, 0, 8'hA1);
        step(1, 0, 1, 8'hA5, 0, 4, 1, 8'hA1);
        step(1, 0, 0, 8'h00, 1, 3, 1, 8'hA2);
        step(1, 0, 0, 8'h00, 1, 2, 1, 8'hA3);
        step(1, 0, 0, 8'h00, 1, 1, 1, 8'hA4);
        step(1, 0, 0, 8'h00, 1, 0, 1, 8'h00);

        // Push into a full queue alongside a pop is legal
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        step(1, 0, 1, 8'h11, 0, 1, 0, 8'h11);
        step(1, 0, 1, 8'h12, 0, 2, 0, 8'h11);
        step(1, 0, 1, 8'h13, 0, 3, 0, 8'h11);
        step(1, 0, 1, 8'h14, 0, 4, 0, 8'h11);
        step(1, 0, 1, 8'hB0, 1, 4, 0, 8'h12);
        step(1, 0, 0, 8'h00, 1, 3, 0, 8'h13);
        step(1, 0, 0, 8'h00, 1, 2, 0, 8'h14);
        step(1, 0, 0, 8'h00, 1, 1, 0, 8'hB0);
        step(1, 0, 0, 8'h00, 1, 0, 0, 8'h00);

        // Wrap-around with steady occupancy of one
        step(1, 0, 1, 8'hFF, 0, 1, 0, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 8'(i), 1, 1, 0, 8'(i));
        end
        step(1, 0, 0, 8'h00, 1, 0, 0, 8'h00);

        // Push and pop on an empty queue: pop is an underflow, push lands
        step(1, 0, 1, 8'hC3, 1, 1, 1, 8'hC3);
        step(1, 0, 1, 8'hD1, 0, 2, 1, 8'hC3);
        step(1, 0, 1, 8'hD2, 0, 3, 1, 8'hC3);

        // Flush discards entries and the concurrent push, err held
        step(1, 1, 1, 8'hE0, 1, 0, 1, 8'h00);
        step(1, 0, 1, 8'hF0, 0, 1, 1, 8'hF0);
        step(0, 0, 1, 8'hF1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        // Lone underflow on empty queue
        step(1, 0, 0, 8'h00, 1, 0, 1, 8'h00);

        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain actual %0d required 0 pending expectations", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

endmodule
